// File: rtl/shift_seq_pkg.sv
// Shared constants for the shift sequencer: data widths, step limit, FSM state
// encodings and the bit layout of the shifter control word.
package shift_seq_pkg;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned AMT_W    = 4;
  localparam int unsigned MAX_STEP = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Control word is {fill, step[1:0], dir}
  localparam int unsigned FILL_BIT = 3;
  localparam int unsigned AMT_MSB  = 2;
  localparam int unsigned AMT_LSB  = 1;
  localparam int unsigned DIR_BIT  = 0;

endpackage

// File: rtl/shift_step_calc.sv
// Combinational step sizing: clamps the remaining amount to the shifter's
// per-step limit and assembles the shifter control word.
module shift_step_calc
  import shift_seq_pkg::*;
(
  input  logic [AMT_W-1:0] rem_i,
  input  logic             dir_i,
  input  logic             fill_i,
  output logic [1:0]       step_o,
  output logic [3:0]       ctrl_o
);

  always_comb begin
    step_o = (rem_i >= AMT_W'(MAX_STEP)) ? 2'(MAX_STEP) : rem_i[1:0];
    ctrl_o                  = '0;
    ctrl_o[FILL_BIT]        = fill_i;
    ctrl_o[AMT_MSB:AMT_LSB] = step_o;
    ctrl_o[DIR_BIT]         = dir_i;
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle controller that splits a 0-15 position shift into steps of at most
// three for an external 4-bit shifter. SHIFT_SEQ_STICKY_OVF_EN makes overflow sticky.
module shift_sequencer
  import shift_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [AMT_W-1:0] in_amt_i,
  input  logic             in_dir_i,
  input  logic             in_fill_i,
  output logic [WIDTH-1:0] sh_a_o,
  output logic [3:0]       sh_b_o,
  input  logic [WIDTH-1:0] sh_x_i,
  input  logic             sh_y_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_ovf_o
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;
  logic             ovf_q, ovf_d;

  logic [1:0]       step;
  logic [3:0]       ctrl;
  logic [AMT_W-1:0] rem_next;

  shift_step_calc u_step_calc (
    .rem_i  (rem_q),
    .dir_i  (dir_q),
    .fill_i (fill_q),
    .step_o (step),
    .ctrl_o (ctrl)
  );

  assign rem_next = rem_q - {{(AMT_W-2){1'b0}}, step};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          acc_d   = in_data_i;
          rem_d   = in_amt_i;
          dir_d   = in_dir_i;
          fill_d  = in_fill_i;
          ovf_d   = 1'b0;
          state_d = (in_amt_i != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        acc_d = sh_x_i;
`ifdef SHIFT_SEQ_STICKY_OVF_EN
        ovf_d = ovf_q | sh_y_i;
`else
        ovf_d = sh_y_i;
`endif
        rem_d = rem_next;
        if (rem_next == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs are gated by state so they sit at zero outside the phase that owns them.
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
    out_data_o  = (state_q == DONE) ? acc_q : '0;
    out_ovf_o   = (state_q == DONE) ? ovf_q : 1'b0;
    sh_a_o      = (state_q == RUN) ? acc_q : '0;
    sh_b_o      = (state_q == RUN) ? ctrl : '0;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with a behavioural shifter and reference model.
// Honours SHIFT_SEQ_STICKY_OVF_EN for the expected overflow behaviour.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic [3:0] in_amt = '0;
  logic       in_dir = 1'b0;
  logic       in_fill = 1'b0;
  logic [3:0] sh_a;
  logic [3:0] sh_b;
  logic [3:0] sh_x;
  logic       sh_y;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic       out_ovf;

  int checks = 0;
  int errors = 0;

  logic       ovr_en = 1'b0;
  int         run_idx = 0;
  logic [3:0] model_x;
  logic       model_y;

  logic [3:0] obs_data;
  logic       obs_ovf;
  int         obs_lat;
  logic [3:0] shq[$];

  shift_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_amt_i    (in_amt),
    .in_dir_i    (in_dir),
    .in_fill_i   (in_fill),
    .sh_a_o      (sh_a),
    .sh_b_o      (sh_b),
    .sh_x_i      (sh_x),
    .sh_y_i      (sh_y),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_ovf_o   (out_ovf)
  );

  always #5 clk = ~clk;

  // One shifter step: overflow means a 1 was shifted out of the word.
  function automatic void shift_model(input logic [3:0] a, input int s, input logic dir,
                                      input logic fill, output logic [3:0] x, output logic y);
    logic [7:0] w;
    logic [3:0] m;
    if (!dir) begin
      w = {4'b0, a} << s;
      m = 4'hF >> (4 - s);
      x = w[3:0] | (fill ? m : 4'b0);
      y = (w[7:4] != 4'b0);
    end else begin
      w = {a, 4'b0} >> s;
      m = 4'hF >> s;
      x = w[7:4] | (fill ? ~m : 4'b0);
      y = (w[3:0] != 4'b0);
    end
  endfunction

  always_comb begin
    model_x = 4'b0;
    model_y = 1'b0;
    if (sh_b[2:1] != 2'b0) shift_model(sh_a, int'(sh_b[2:1]), sh_b[0], sh_b[3], model_x, model_y);
  end

  assign sh_x = model_x;
  assign sh_y = ovr_en ? (run_idx == 0) : model_y;

  always @(posedge clk) begin
    if (in_ready) run_idx <= 0;
    else if (sh_b != 4'b0) run_idx <= run_idx + 1;
  end

  function automatic void ref_model(input logic [3:0] d, input int amt, input logic dir,
                                    input logic fill, output logic [3:0] rd, output logic rovf,
                                    output int rlat);
    int rem;
    int s;
    logic y;
    rd = d;
    rovf = 1'b0;
    rem = amt;
    rlat = (amt + 2) / 3 + 1;
    while (rem > 0) begin
      s = (rem > 3) ? 3 : rem;
      shift_model(rd, s, dir, fill, rd, y);
`ifdef SHIFT_SEQ_STICKY_OVF_EN
      rovf = rovf | y;
`else
      rovf = y;
`endif
      rem -= s;
    end
  endfunction

  // Issues one request and waits (bounded) for out_valid; leaves out_ready low.
  task automatic send(input logic [3:0] d, input logic [3:0] a, input logic dir,
                      input logic fill);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_dir   = dir;
    in_fill  = fill;
    @(negedge clk);
    in_valid = 1'b0;
    obs_lat  = 1;
    shq.delete();
    while (!out_valid && obs_lat < 30) begin
      if (sh_b != 4'b0) shq.push_back(sh_b);
      @(negedge clk);
      obs_lat++;
    end
    obs_data = out_data;
    obs_ovf  = out_ovf;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_data, out_ovf, sh_a, sh_b} !== {1'b1, 1'b0, 4'h0, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL reset_held: got rdy=%b vld=%b d=%h o=%b a=%h b=%h, want 1 0 0 0 0 0",
               in_ready, out_valid, out_data, out_ovf, sh_a, sh_b);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, sh_b} !== {1'b1, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b vld=%b b=%h, want 1 0 0", in_ready, out_valid, sh_b);
    end
  endtask

  task automatic test_single_step();
    send(4'b1010, 4'd1, 1'b0, 1'b0);
    checks++;
    if (obs_data !== 4'b0100 || obs_lat != 2 || shq.size() != 1 || shq[0] !== 4'b0010) begin
      errors++;
      $display("FAIL single_step: got d=%b lat=%0d nsteps=%0d b0=%b, want 0100 2 1 0010",
               obs_data, obs_lat, shq.size(), shq[0]);
    end
    release_out();
  endtask

  task automatic test_two_steps();
    send(4'b1010, 4'd5, 1'b1, 1'b1);
    checks++;
    if (obs_data !== 4'b1111 || obs_lat != 3 || shq.size() != 2 ||
        shq[0] !== 4'b1111 || shq[1] !== 4'b1101) begin
      errors++;
      $display("FAIL two_steps: got d=%b lat=%0d nsteps=%0d b=%b,%b, want 1111 3 2 1111,1101",
               obs_data, obs_lat, shq.size(), shq[0], shq[1]);
    end
    release_out();
  endtask

  task automatic test_amount_zero();
    send(4'b0110, 4'd0, 1'b0, 1'b1);
    checks++;
    if (obs_data !== 4'b0110 || obs_ovf !== 1'b0 || obs_lat != 1 || shq.size() != 0 ||
        sh_b !== 4'b0) begin
      errors++;
      $display("FAIL amount_zero: got d=%b ovf=%b lat=%0d nsteps=%0d, want 0110 0 1 0",
               obs_data, obs_ovf, obs_lat, shq.size());
    end
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL return_idle: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] rd;
    logic       rovf;
    int         rlat;
    int         lat2;
    send(4'b0111, 4'd4, 1'b0, 1'b1);
    ref_model(4'b0111, 4, 1'b0, 1'b1, rd, rovf, rlat);
    // Second request waits while the first result is held off.
    in_valid = 1'b1;
    in_data  = 4'b1001;
    in_amt   = 4'd2;
    in_dir   = 1'b1;
    in_fill  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== rd || out_ovf !== rovf || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold%0d: got vld=%b d=%h o=%b rdy=%b, want 1 %h %b 0",
                 i, out_valid, out_data, out_ovf, in_ready, rd, rovf);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_idle: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL second_accept: got rdy=%b, want 0", in_ready);
    end
    lat2 = 1;
    while (!out_valid && lat2 < 30) begin
      @(negedge clk);
      lat2++;
    end
    ref_model(4'b1001, 2, 1'b1, 1'b0, rd, rovf, rlat);
    checks++;
    if (out_valid !== 1'b1 || out_data !== rd || out_ovf !== rovf || lat2 != rlat) begin
      errors++;
      $display("FAIL second_result: got vld=%b d=%h o=%b lat=%0d, want 1 %h %b %0d",
               out_valid, out_data, out_ovf, lat2, rd, rovf, rlat);
    end
    release_out();
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] rd;
    logic       rovf;
    int         rlat;
    int         seen;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'b1011;
    in_amt   = 4'd15;
    in_dir   = 1'b0;
    in_fill  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, out_data, out_ovf, sh_a, sh_b} !== {1'b1, 1'b0, 4'h0, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL reset_mid_run: got rdy=%b vld=%b d=%h o=%b a=%h b=%h, want 1 0 0 0 0 0",
               in_ready, out_valid, out_data, out_ovf, sh_a, sh_b);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_result: got %0d valid cycles, want 0", seen);
    end
    send(4'b1100, 4'd7, 1'b1, 1'b0);
    ref_model(4'b1100, 7, 1'b1, 1'b0, rd, rovf, rlat);
    checks++;
    if (obs_data !== rd || obs_ovf !== rovf || obs_lat != rlat) begin
      errors++;
      $display("FAIL after_reset: got d=%h o=%b lat=%0d, want %h %b %0d",
               obs_data, obs_ovf, obs_lat, rd, rovf, rlat);
    end
    release_out();
  endtask

  task automatic test_overflow();
    logic exp_ovf;
`ifdef SHIFT_SEQ_STICKY_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    ovr_en = 1'b1;
    send(4'b0001, 4'd5, 1'b0, 1'b0);
    ovr_en = 1'b0;
    checks++;
    if (obs_ovf !== exp_ovf || obs_data !== 4'b0000 || obs_lat != 3) begin
      errors++;
      $display("FAIL overflow_first_step: got ovf=%b d=%b lat=%0d, want %b 0000 3",
               obs_ovf, obs_data, obs_lat, exp_ovf);
    end
    release_out();
  endtask

  task automatic test_random();
    logic [3:0] d;
    logic [3:0] a;
    logic       dir;
    logic       fill;
    logic [3:0] rd;
    logic       rovf;
    int         rlat;
    for (int i = 0; i < 40; i++) begin
      d    = 4'($urandom_range(0, 15));
      a    = 4'($urandom_range(0, 15));
      dir  = 1'($urandom_range(0, 1));
      fill = 1'($urandom_range(0, 1));
      send(d, a, dir, fill);
      ref_model(d, int'(a), dir, fill, rd, rovf, rlat);
      checks++;
      if (obs_data !== rd || obs_ovf !== rovf || obs_lat != rlat || shq.size() != rlat - 1) begin
        errors++;
        $display("FAIL random%0d d=%h a=%0d dir=%b f=%b: got %h %b lat=%0d n=%0d, want %h %b %0d",
                 i, d, a, dir, fill, obs_data, obs_ovf, obs_lat, shq.size(), rd, rovf, rlat);
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_two_steps();
    test_amount_zero();
    test_backpressure();
    test_reset_mid_run();
    test_overflow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
